// File: rtl/procyon_cdb_tx_if.sv
// Result-side and CDB-side handshake bundle for one CDB transmit slot.
// slave modport is the slot itself; master is the functional unit / arbiter side.
interface procyon_cdb_tx_if #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5
);
  logic                          i_result_valid;
  logic                          o_result_ready;
  logic [OPTN_DATA_WIDTH-1:0]    i_result_data;
  logic [OPTN_ROB_IDX_WIDTH-1:0] i_result_tag;
  logic                          i_result_redirect;
  logic                          o_cdb_req;
  logic                          i_cdb_gnt;
  logic                          o_cdb_en;
  logic                          o_cdb_redirect;
  logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data;
  logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag;

  modport slave (
    input  i_result_valid, i_result_data, i_result_tag, i_result_redirect, i_cdb_gnt,
    output o_result_ready, o_cdb_req, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_tag
  );

  modport master (
    output i_result_valid, i_result_data, i_result_tag, i_result_redirect, i_cdb_gnt,
    input  o_result_ready, o_cdb_req, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_tag
  );
endinterface

// File: rtl/procyon_cdb_tx.sv
// Queues completed results and broadcasts one per granted cycle onto the CDB.
// Latency: enqueue N -> request N+1 -> broadcast the cycle after the grant; ready depends on registered count only.
module procyon_cdb_tx #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_TXQ_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  procyon_cdb_tx_if.slave       bus
);
  localparam int PW = $clog2(OPTN_TXQ_DEPTH);
  localparam int CW = PW + 1;

  logic [OPTN_DATA_WIDTH-1:0]    r_data  [OPTN_TXQ_DEPTH];
  logic [OPTN_ROB_IDX_WIDTH-1:0] r_tag   [OPTN_TXQ_DEPTH];
  logic                          r_redir [OPTN_TXQ_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic                          r_cdb_en;
  logic                          r_cdb_redirect;
  logic [OPTN_DATA_WIDTH-1:0]    r_cdb_data;
  logic [OPTN_ROB_IDX_WIDTH-1:0] r_cdb_tag;

  logic w_ready;
  logic w_req;
  logic w_enq;
  logic w_deq;

  // Ready from registered count only, so a full queue refuses even when it drains this cycle.
  assign w_ready = (r_count < CW'(OPTN_TXQ_DEPTH)) & ~rst;
  assign w_req   = (r_count != '0) & ~i_redirect & ~rst;
  assign w_enq   = bus.i_result_valid & w_ready & ~i_redirect;
  assign w_deq   = w_req & bus.i_cdb_gnt;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data[r_tail]  <= bus.i_result_data;
      r_tag[r_tail]   <= bus.i_result_tag;
      r_redir[r_tail] <= bus.i_result_redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_cdb_en       <= 1'b0;
      r_cdb_redirect <= 1'b0;
      r_cdb_data     <= '0;
      r_cdb_tag      <= '0;
    end else if (i_redirect) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cdb_en <= 1'b0;
    end else begin
      r_cdb_en <= w_deq;
      if (w_deq) begin
        r_cdb_data     <= r_data[r_head];
        r_cdb_tag      <= r_tag[r_head];
        r_cdb_redirect <= r_redir[r_head];
        r_head         <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_result_ready = w_ready;
  assign bus.o_cdb_req      = w_req;
  assign bus.o_cdb_en       = r_cdb_en;
  assign bus.o_cdb_redirect = r_cdb_redirect;
  assign bus.o_cdb_data     = r_cdb_data;
  assign bus.o_cdb_tag      = r_cdb_tag;
endmodule
